cache_fill_arbiter: RTL and testbench

- Sequences the single shared unified main memory between the I-cache and the D-cache of the 5-stage pipelined cpu.
- On a cache miss it issues the 8 word reads of the missing 16-byte block to the pipelined memory and steers the returned words into the owning cache's data array.
- It also performs D-cache write-through stores.
- Sits between the two cache controllers and the memory model. The pipeline stalls while the relevant miss or store is outstanding.

---
 rtl/cache_fill_arbiter_pkg.sv | 19 +
 rtl/cache_fill_arbiter_if.sv | 52 +++++
 rtl/cache_fill_arbiter_block_addr_gen.sv | 57 +++++
 rtl/cache_fill_arbiter.sv | 135 +++++++++++++
 tb/tb_cache_fill_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_fill_arbiter_pkg.sv
// Shared types and block geometry for the I/D cache fill arbiter.
// A block is 8 sixteen-bit words, always 16-byte aligned.
package cache_fill_pkg;

    localparam int          BLOCK_WORDS = 8;
    localparam int          WORD_IDX_W  = 3;
    localparam logic [15:0] BLOCK_MASK  = 16'hFFF0;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/cache_fill_arbiter_if.sv
// Cache-controller and memory-side signals of the fill arbiter.
// slave = arbiter side, master = caches plus memory model.
interface cache_fill_arbiter_if
    import cache_fill_pkg::WORD_IDX_W;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) ();

    logic                  i_miss_req;
    logic [ADDR_W-1:0]     i_miss_addr;
    logic                  d_miss_req;
    logic [ADDR_W-1:0]     d_miss_addr;
    logic                  d_wr_req;
    logic [ADDR_W-1:0]     d_wr_addr;
    logic [DATA_W-1:0]     d_wr_data;

    logic                  i_fill_we;
    logic                  d_fill_we;
    logic [WORD_IDX_W-1:0] fill_word;
    logic [DATA_W-1:0]     fill_data;
    logic                  i_fill_done;
    logic                  d_fill_done;
    logic                  d_wr_ack;
    logic                  busy;

    logic                  mem_en;
    logic                  mem_wr;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  mem_rvalid;

    modport slave (
        input  i_miss_req, i_miss_addr, d_miss_req, d_miss_addr,
        input  d_wr_req, d_wr_addr, d_wr_data,
        input  mem_rdata, mem_rvalid,
        output i_fill_we, d_fill_we, fill_word, fill_data,
        output i_fill_done, d_fill_done, d_wr_ack, busy,
        output mem_en, mem_wr, mem_addr, mem_wdata
    );

    modport master (
        output i_miss_req, i_miss_addr, d_miss_req, d_miss_addr,
        output d_wr_req, d_wr_addr, d_wr_data,
        output mem_rdata, mem_rvalid,
        input  i_fill_we, d_fill_we, fill_word, fill_data,
        input  i_fill_done, d_fill_done, d_wr_ack, busy,
        input  mem_en, mem_wr, mem_addr, mem_wdata
    );

endinterface

// File: rtl/cache_fill_arbiter_block_addr_gen.sv
// Block base, issue and receive counters for one fill; issue addresses are combinational.
// Receive count is advanced only by returned data, so completion is latency independent.
module block_addr_gen
    import cache_fill_pkg::WORD_IDX_W;
    import cache_fill_pkg::BLOCK_MASK;
#(
    parameter int BLOCK_WORDS = 8,
    parameter int ADDR_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic [ADDR_W-1:0]     i_miss_addr,
    input  logic                  i_issue,
    input  logic                  i_rcv,
    input  logic                  i_clear,
    output logic [ADDR_W-1:0]     o_mem_addr,
    output logic [WORD_IDX_W-1:0] o_fill_word,
    output logic                  o_issue_done,
    output logic                  o_last_word
);

    logic [ADDR_W-1:0]     r_base;
    logic [WORD_IDX_W:0]   r_issue_cnt;
    logic [WORD_IDX_W-1:0] r_rcv_cnt;
    logic [ADDR_W-1:0]     w_byte_ofs;

    // Offset never exceeds the block, so the sum stays inside it even at 0xFFF0.
    assign w_byte_ofs   = ADDR_W'({r_issue_cnt[WORD_IDX_W-1:0], 1'b0});
    assign o_mem_addr   = r_base + w_byte_ofs;
    assign o_fill_word  = r_rcv_cnt;
    assign o_issue_done = (r_issue_cnt == (WORD_IDX_W+1)'(BLOCK_WORDS));
    assign o_last_word  = (r_rcv_cnt == WORD_IDX_W'(BLOCK_WORDS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base      <= '0;
            r_issue_cnt <= '0;
            r_rcv_cnt   <= '0;
        end else if (i_load) begin
            r_base      <= i_miss_addr & ADDR_W'(BLOCK_MASK);
            r_issue_cnt <= '0;
            r_rcv_cnt   <= '0;
        end else if (i_clear) begin
            r_issue_cnt <= '0;
            r_rcv_cnt   <= '0;
        end else begin
            if (i_issue && !o_issue_done) begin
                r_issue_cnt <= r_issue_cnt + 1'b1;
            end
            if (i_rcv) begin
                r_rcv_cnt <= r_rcv_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cache_fill_arbiter.sv
// Shares one pipelined memory between I and D caches: write-through stores, then 8-word block fills.
// Stores are acked combinationally in IDLE; every request waits while a fill is in flight.
module cache_fill_arbiter
    import cache_fill_pkg::WORD_IDX_W;
    import cache_fill_pkg::arb_state_t;
    import cache_fill_pkg::owner_t;
    import cache_fill_pkg::IDLE;
    import cache_fill_pkg::FILL;
    import cache_fill_pkg::OWN_I;
    import cache_fill_pkg::OWN_D;
#(
    parameter int BLOCK_WORDS = 8,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16
) (
    input logic                 clk,
    input logic                 rst,
    cache_fill_arbiter_if.slave bus
);

    arb_state_t            r_state;
    owner_t                r_owner;

    logic                  w_idle;
    logic                  w_fill;
    logic                  w_grant_wr;
    logic                  w_grant_miss;
    logic                  w_issue;
    logic                  w_rcv;
    logic                  w_done;
    logic                  w_issue_done;
    logic                  w_last_word;
    logic [ADDR_W-1:0]     w_miss_addr;
    logic [ADDR_W-1:0]     w_blk_addr;
    logic [WORD_IDX_W-1:0] w_fill_word;

    // rst is folded in so outputs drop the instant reset rises, not at the next edge.
    assign w_idle       = (r_state == IDLE) && !rst;
    assign w_fill       = (r_state == FILL) && !rst;
    assign w_grant_wr   = w_idle && bus.d_wr_req;
    assign w_grant_miss = w_idle && !bus.d_wr_req && (bus.d_miss_req || bus.i_miss_req);
    assign w_miss_addr  = bus.d_miss_req ? bus.d_miss_addr : bus.i_miss_addr;
    assign w_issue      = w_fill && !w_issue_done;
    assign w_rcv        = w_fill && bus.mem_rvalid;
    assign w_done       = w_rcv && w_last_word;

    block_addr_gen #(
        .BLOCK_WORDS (BLOCK_WORDS),
        .ADDR_W      (ADDR_W)
    ) u_addr_gen (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_grant_miss),
        .i_miss_addr  (w_miss_addr),
        .i_issue      (w_issue),
        .i_rcv        (w_rcv),
        .i_clear      (w_done),
        .o_mem_addr   (w_blk_addr),
        .o_fill_word  (w_fill_word),
        .o_issue_done (w_issue_done),
        .o_last_word  (w_last_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_owner <= OWN_I;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_miss) begin
                        r_state <= FILL;
                        r_owner <= bus.d_miss_req ? OWN_D : OWN_I;
                    end
                end
                FILL: begin
                    if (w_done) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.mem_en      = 1'b0;
        bus.mem_wr      = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_wdata   = '0;
        bus.d_wr_ack    = 1'b0;
        bus.i_fill_we   = 1'b0;
        bus.d_fill_we   = 1'b0;
        bus.fill_word   = '0;
        bus.fill_data   = '0;
        bus.i_fill_done = 1'b0;
        bus.d_fill_done = 1'b0;

        if (w_grant_wr) begin
            bus.mem_en    = 1'b1;
            bus.mem_wr    = 1'b1;
            bus.mem_addr  = bus.d_wr_addr;
            bus.mem_wdata = bus.d_wr_data;
            bus.d_wr_ack  = 1'b1;
        end else if (w_issue) begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = w_blk_addr;
        end

        // Returned data may overlap issue; only the owner's array is written.
        if (w_rcv) begin
            bus.fill_word = w_fill_word;
            bus.fill_data = bus.mem_rdata;
            if (r_owner == OWN_D) begin
                bus.d_fill_we   = 1'b1;
                bus.d_fill_done = w_last_word;
            end else begin
                bus.i_fill_we   = 1'b1;
                bus.i_fill_done = w_last_word;
            end
        end
    end

    assign bus.busy = (r_state == FILL);

    a_no_miss_with_store: assert property (@(posedge clk) disable iff (rst)
        !(bus.d_miss_req && bus.d_wr_req));

    a_i_miss_held: assert property (@(posedge clk) disable iff (rst)
        (r_state == FILL && r_owner == OWN_I) |-> bus.i_miss_req);

    a_d_miss_held: assert property (@(posedge clk) disable iff (rst)
        (r_state == FILL && r_owner == OWN_D) |-> bus.d_miss_req);

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed bench for cache_fill_arbiter with a pipelined memory model and in-order scoreboards.
module tb_cache_fill_arbiter;

    typedef struct packed {
        logic        own;
        logic [2:0]  word;
        logic [15:0] data;
        logic        last;
    } exp_fill_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } exp_wr_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_fill_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    cache_fill_arbiter #(
        .BLOCK_WORDS (8),
        .ADDR_W      (16),
        .DATA_W      (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          vec_cnt = 0;
    int          miss_cnt = 0;
    int          cyc = 0;
    int          lat = 4;
    exp_fill_t   exp_fill_q[$];
    logic [15:0] exp_addr_q[$];
    exp_wr_t     exp_wr_q[$];
    int          rd_cyc_q[$];
    int          we_cyc_q[$];
    int          i_done_cyc = -1;
    int          d_done_cyc = -1;
    int          wr_cyc = -1;
    int          busy_fall_cyc = -1;
    int          stray_seen = 0;
    logic        prev_busy = 1'b0;

    function automatic logic [15:0] mdata(input logic [15:0] a);
        return a ^ 16'hC3A5;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        vec_cnt++;
        assert (obs === want) else begin
            miss_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic zero_check(input string tag);
        chk({tag, "_ctrl"}, 32'({bus.i_fill_we, bus.d_fill_we, bus.i_fill_done, bus.d_fill_done,
                                 bus.d_wr_ack, bus.busy, bus.mem_en, bus.mem_wr, bus.fill_word}), 32'd0);
        chk({tag, "_addr"}, 32'(bus.mem_addr), 32'd0);
        chk({tag, "_data"}, {bus.fill_data, bus.mem_wdata}, 32'd0);
    endtask

    task automatic push_miss(input logic own, input logic [15:0] addr);
        logic [15:0] base;
        logic [15:0] a;
        exp_fill_t   ef;
        base = addr & 16'hFFF0;
        for (int w = 0; w < 8; w++) begin
            a = base + 16'(2 * w);
            exp_addr_q.push_back(a);
            ef.own  = own;
            ef.word = 3'(w);
            ef.data = mdata(a);
            ef.last = (w == 7);
            exp_fill_q.push_back(ef);
        end
    endtask

    // Pipelined memory: a read seen in cycle c returns in cycle c+lat, in order.
    initial begin : mem_model
        logic [16:0] pipe [8];
        logic        cap_en;
        logic [15:0] cap_addr;
        for (int i = 0; i < 8; i++) pipe[i] = '0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        forever begin
            @(negedge clk);
            cap_en   = bus.mem_en && !bus.mem_wr;
            cap_addr = bus.mem_addr;
            @(posedge clk);
            #1;
            for (int i = 7; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0]        = {cap_en, cap_addr};
            bus.mem_rvalid = pipe[lat-1][16];
            bus.mem_rdata  = pipe[lat-1][16] ? mdata(pipe[lat-1][15:0]) : 16'h0;
        end
    end

    // One cycle: check outputs mid-cycle, then move to just after the next rising edge.
    task automatic tick();
        exp_fill_t ef;
        exp_wr_t   ew;
        logic      drop_i;
        logic      drop_d;
        logic      drop_w;
        @(negedge clk);
        cyc++;
        drop_i = bus.i_fill_done;
        drop_d = bus.d_fill_done;
        drop_w = bus.d_wr_ack;
        if (bus.mem_en && !bus.mem_wr) begin
            rd_cyc_q.push_back(cyc);
            chk("read_expected", 32'(exp_addr_q.size() != 0), 32'd1);
            if (exp_addr_q.size() != 0) chk("read_addr", 32'(bus.mem_addr), 32'(exp_addr_q.pop_front()));
        end
        if (bus.mem_en && bus.mem_wr) begin
            wr_cyc = cyc;
            chk("wr_ack", 32'(bus.d_wr_ack), 32'd1);
            chk("wr_expected", 32'(exp_wr_q.size() != 0), 32'd1);
            if (exp_wr_q.size() != 0) begin
                ew = exp_wr_q.pop_front();
                chk("wr_addr", 32'(bus.mem_addr), 32'(ew.addr));
                chk("wr_data", 32'(bus.mem_wdata), 32'(ew.data));
            end
        end
        if (!bus.mem_en && (bus.mem_wr || bus.mem_addr != 16'h0 || bus.mem_wdata != 16'h0))
            chk("idle_mem_zero", {bus.mem_addr, bus.mem_wdata}, 32'd0);
        if (bus.i_fill_we || bus.d_fill_we) begin
            we_cyc_q.push_back(cyc);
            chk("fill_overlap", 32'(bus.i_fill_we && bus.d_fill_we), 32'd0);
            chk("fill_expected", 32'(exp_fill_q.size() != 0), 32'd1);
            if (exp_fill_q.size() != 0) begin
                ef = exp_fill_q.pop_front();
                chk("fill_owner", 32'(bus.d_fill_we), 32'(ef.own));
                chk("fill_word", 32'(bus.fill_word), 32'(ef.word));
                chk("fill_data", 32'(bus.fill_data), 32'(ef.data));
                chk("i_fill_done", 32'(bus.i_fill_done), 32'(ef.last && !ef.own));
                chk("d_fill_done", 32'(bus.d_fill_done), 32'(ef.last && ef.own));
            end
        end else begin
            if (bus.i_fill_done || bus.d_fill_done)
                chk("done_without_we", 32'({bus.i_fill_done, bus.d_fill_done}), 32'd0);
            if (bus.fill_data != 16'h0 || bus.fill_word != 3'd0)
                chk("idle_fill_zero", 32'({bus.fill_word, bus.fill_data}), 32'd0);
        end
        if (bus.i_fill_done) i_done_cyc = cyc;
        if (bus.d_fill_done) d_done_cyc = cyc;
        if (bus.mem_rvalid && !bus.busy) stray_seen++;
        if (prev_busy && !bus.busy) busy_fall_cyc = cyc;
        prev_busy = bus.busy;
        @(posedge clk);
        #1;
        if (drop_i) bus.i_miss_req = 1'b0;
        if (drop_d) bus.d_miss_req = 1'b0;
        if (drop_w) bus.d_wr_req   = 1'b0;
    endtask

    task automatic wait_quiet(input string tag, input int limit);
        int n = 0;
        while ((bus.busy || bus.i_miss_req || bus.d_miss_req || bus.d_wr_req ||
                exp_fill_q.size() != 0 || exp_addr_q.size() != 0 || exp_wr_q.size() != 0) && n < limit) begin
            tick();
            n++;
        end
        chk(tag, 32'(n < limit), 32'd1);
        tick();
        tick();
    endtask

    task automatic new_test();
        rd_cyc_q.delete();
        we_cyc_q.delete();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int      t0;
        exp_wr_t ew;

        rst             = 1'b1;
        bus.i_miss_req  = 1'b0;
        bus.i_miss_addr = '0;
        bus.d_miss_req  = 1'b0;
        bus.d_miss_addr = '0;
        bus.d_wr_req    = 1'b1;
        bus.d_wr_addr   = 16'h1111;
        bus.d_wr_data   = 16'h2222;
        #2;
        zero_check("reset");
        repeat (2) @(posedge clk);
        #1;
        bus.d_wr_req = 1'b0;
        rst          = 1'b0;
        tick();

        // I-miss at 0x1234, 4-cycle memory
        new_test();
        bus.i_miss_addr = 16'h1234;
        bus.i_miss_req  = 1'b1;
        push_miss(1'b0, 16'h1234);
        t0 = cyc + 1;
        wait_quiet("t1_timeout", 40);
        chk("t1_reads", 32'(rd_cyc_q.size()), 32'd8);
        chk("t1_rd_first", 32'(rd_cyc_q[0]), 32'(t0 + 1));
        chk("t1_rd_last", 32'(rd_cyc_q[7]), 32'(t0 + 8));
        chk("t1_we_first", 32'(we_cyc_q[0]), 32'(t0 + 5));
        chk("t1_we_last", 32'(we_cyc_q[7]), 32'(t0 + 12));
        chk("t1_done_cyc", 32'(i_done_cyc), 32'(t0 + 12));
        chk("t1_busy_low", 32'(busy_fall_cyc), 32'(t0 + 13));

        // Simultaneous I and D misses: D first
        new_test();
        bus.d_miss_addr = 16'h8006;
        bus.i_miss_addr = 16'h1000;
        bus.d_miss_req  = 1'b1;
        bus.i_miss_req  = 1'b1;
        push_miss(1'b1, 16'h8006);
        push_miss(1'b0, 16'h1000);
        wait_quiet("t2_timeout", 80);
        chk("t2_fills", 32'(we_cyc_q.size()), 32'd16);
        chk("t2_i_grant", 32'(rd_cyc_q[8]), 32'(d_done_cyc + 2));
        chk("t2_i_done", 32'(i_done_cyc), 32'(we_cyc_q[15]));

        // Store and I-miss together in IDLE
        new_test();
        ew.addr = 16'h4002;
        ew.data = 16'hBEEF;
        exp_wr_q.push_back(ew);
        bus.d_wr_addr   = 16'h4002;
        bus.d_wr_data   = 16'hBEEF;
        bus.d_wr_req    = 1'b1;
        bus.i_miss_addr = 16'h5000;
        bus.i_miss_req  = 1'b1;
        push_miss(1'b0, 16'h5000);
        t0 = cyc + 1;
        wait_quiet("t3_timeout", 40);
        chk("t3_wr_cyc", 32'(wr_cyc), 32'(t0));
        chk("t3_rd_first", 32'(rd_cyc_q[0]), 32'(t0 + 2));

        // Store raised during an I fill waits for IDLE
        new_test();
        bus.i_miss_addr = 16'h2000;
        bus.i_miss_req  = 1'b1;
        push_miss(1'b0, 16'h2000);
        repeat (3) tick();
        ew.addr = 16'h4004;
        ew.data = 16'h1111;
        exp_wr_q.push_back(ew);
        bus.d_wr_addr = 16'h4004;
        bus.d_wr_data = 16'h1111;
        bus.d_wr_req  = 1'b1;
        wait_quiet("t4_timeout", 40);
        chk("t4_wr_after_done", 32'(wr_cyc), 32'(i_done_cyc + 1));

        // Reset in cycle 6 of a fill, stray returns, then a fresh D fill
        new_test();
        bus.i_miss_addr = 16'h3008;
        bus.i_miss_req  = 1'b1;
        push_miss(1'b0, 16'h3008);
        repeat (6) tick();
        rst            = 1'b1;
        bus.i_miss_req = 1'b0;
        exp_fill_q.delete();
        exp_addr_q.delete();
        #1;
        zero_check("midfill_rst");
        chk("t5_reads_before_rst", 32'(rd_cyc_q.size()), 32'd5);
        chk("t5_fills_before_rst", 32'(we_cyc_q.size()), 32'd1);
        stray_seen = 0;
        tick();
        rst = 1'b0;
        repeat (6) tick();
        chk("t5_strays", 32'(stray_seen), 32'd4);
        new_test();
        bus.d_miss_addr = 16'h301C;
        bus.d_miss_req  = 1'b1;
        push_miss(1'b1, 16'h301C);
        wait_quiet("t5_timeout", 40);
        chk("t5_refill", 32'(we_cyc_q.size()), 32'd8);

        // Top block with 1-cycle memory: returns overlap issue, no wrap
        new_test();
        lat = 1;
        bus.i_miss_addr = 16'hFFFA;
        bus.i_miss_req  = 1'b1;
        push_miss(1'b0, 16'hFFFA);
        wait_quiet("t6_timeout", 40);
        chk("t6_fills", 32'(we_cyc_q.size()), 32'd8);
        chk("t6_we_first", 32'(we_cyc_q[0]), 32'(rd_cyc_q[0] + 1));
        chk("t6_done_cyc", 32'(i_done_cyc), 32'(rd_cyc_q[7] + 1));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
